sync_down_counter: RTL and testbench

- Synchronous, loadable WIDTH-bit down counter/timer: the counting-down counterpart to the existing 8-bit up-counting ripple counter.
- All flops share one clock edge (posedge clk), so there is no ripple delay between bits.
- Counts a programmed value down to zero and flags terminal count.
- Supports one-shot and auto-reload (periodic) modes, so it serves as the general event/delay timer for other blocks.

---
 rtl/sync_down_counter.sv | 75 +++++++
 tb/tb_sync_down_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter/timer with one-shot and auto-reload modes.
// Latency: load to Q in 1 clk; tc registered, N enabled edges after a load of N.
// Backpressure: none; en gates counting, load always wins.
module sync_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            Q          <= ZERO;
            reload_reg <= ZERO;
            tc         <= 1'b0;
        end else if (load) begin
            Q          <= load_val;
            reload_reg <= load_val;
            tc         <= 1'b0;
            state      <= (load_val != ZERO) ? RUN : IDLE;
        end else begin
            tc <= 1'b0;
            case (state)
                RUN: begin
                    if (en) begin
                        // Q==0 cannot occur in RUN; treating <=1 as terminal keeps the
                        // subtraction from ever wrapping to all-ones.
                        if (Q <= ONE) begin
                            tc <= 1'b1;
                            if (auto_reload) begin
                                Q <= reload_reg;
                            end else begin
                                Q     <= ZERO;
                                state <= DONE;
                            end
                        end else begin
                            Q <= Q - ONE;
                        end
                    end
                end
                DONE: begin
                    Q <= ZERO;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sync_down_counter.sv
// Vector table plus hand-written sequences for sync_down_counter (WIDTH=8).
module tb_sync_down_counter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    sync_down_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_val),
        .en         (en),
        .auto_reload(auto_reload),
        .Q          (q),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         en;
        logic         ar;
        logic [W-1:0] q;
        logic         tc;
        logic         busy;
        logic         done;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic         tc;
        logic         busy;
        logic         done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [W-1:0] lv, input logic e,
                                input logic ar, input logic [W-1:0] eq, input logic etc,
                                input logic eb, input logic ed);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = e; v.ar = ar;
        v.q = eq; v.tc = etc; v.busy = eb; v.done = ed;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic apply(input string nm, input vec_t v);
        exp_t x;
        @(negedge clk);
        load = v.ld; load_val = v.lv; en = v.en; auto_reload = v.ar;
        x.q = v.q; x.tc = v.tc; x.busy = v.busy; x.done = v.done;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({nm, ".sb_empty"}, 1, 0);
        end else begin
            x = sb.pop_front();
            chk({nm, ".Q"}, q, x.q);
            chk({nm, ".tc"}, tc, x.tc);
            chk({nm, ".busy"}, busy, x.busy);
            chk({nm, ".done"}, done, x.done);
        end
    endtask

    initial begin
        int n;
        int bad;
        bit seen;

        reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.Q", q, 0);
        chk("rst.tc", tc, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        // one-shot 5 -> 0, then DONE held
        vecs.push_back(mk(1, 5, 1, 0, 5, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
        // auto-reload 3
        vecs.push_back(mk(1, 3, 1, 1, 3, 0, 1, 0));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(0, 0, 1, 1, 2, 0, 1, 0));
            vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0));
            vecs.push_back(mk(0, 0, 1, 1, 3, 1, 1, 0));
        end
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 1, 0));
        // enable gating 1,0,0,1,1,0,1
        vecs.push_back(mk(1, 4, 1, 0, 4, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        // load on the terminal-count edge, then load of zero
        vecs.push_back(mk(1, 2, 1, 1, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 2, 1, 1, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 2, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
        // reload value 1: tc every enabled cycle
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0));
        // auto_reload dropped mid-period
        vecs.push_back(mk(1, 2, 1, 1, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 2, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
        // auto_reload only matters on the terminal edge
        vecs.push_back(mk(1, 3, 1, 0, 3, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 3, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("v%0d", i), vecs[i]);

        // full-range count from 0xFF
        apply("ff.load", mk(1, 8'hFF, 1, 0, 8'hFF, 0, 1, 0));
        n = 0; bad = 0; seen = 0;
        for (int k = 1; k <= 300 && !seen; k++) begin
            @(negedge clk);
            load = 1'b0; en = 1'b1; auto_reload = 1'b0;
            @(posedge clk);
            #1;
            if (tc) begin
                seen = 1;
                n = k;
            end else if (k < 255 && q !== W'(255 - k)) begin
                bad++;
            end
        end
        chk("ff.tc_edges", n, 255);
        chk("ff.q_track_errors", bad, 0);
        chk("ff.Q_end", q, 0);
        chk("ff.done", done, 1);

        // asynchronous reset mid-count, between edges
        apply("ar.load", mk(1, 8'h38, 0, 0, 8'h38, 0, 1, 0));
        apply("ar.dec", mk(0, 0, 1, 0, 8'h37, 0, 1, 0));
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("arst.Q", q, 0);
        chk("arst.tc", tc, 0);
        chk("arst.busy", busy, 0);
        chk("arst.done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        apply("rel.load", mk(1, 9, 0, 0, 9, 0, 1, 0));
        apply("rel.dec", mk(0, 0, 1, 0, 8, 0, 1, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
